// File: rtl/axi4_pkg.sv
// AXI4 burst-type and response encodings shared by the AXI4 bridges.
package axi4_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/pi1_pkg.sv
// PerInt (pi1) bus operation codes shared by pi1 masters and slaves.
package pi1_pkg;

  typedef enum logic [1:0] {
    PINOOP = 2'b00,
    PIWROP = 2'b01,
    PIRDOP = 2'b10,
    PIRWOP = 2'b11
  } pi1_op_e;

endpackage

// File: rtl/axi4_burst_addr.sv
// Next beat address for an AXI4 burst, plus a flag for bursts the bridge
// cannot serve (WRAP, reserved type, or a beat wider than the bus).
module axi4_burst_addr
  import axi4_pkg::*;
#(
  parameter int ARCHBITSZ = 32
) (
  input  logic [ARCHBITSZ-1:0] addr,
  input  logic [2:0]           size,
  input  logic [1:0]           burst,
  output logic [ARCHBITSZ-1:0] next_addr,
  output logic                 err
);

  localparam logic [2:0] MAXSIZE = 3'($clog2(ARCHBITSZ/8));

  always_comb begin
    err       = (size > MAXSIZE) || !((burst == BURST_FIXED) || (burst == BURST_INCR));
    // Wraps modulo 2^ARCHBITSZ; 4KB crossings are the initiator's problem.
    next_addr = (burst == BURST_INCR) ? addr + (ARCHBITSZ'(1) << size) : addr;
  end

endmodule

// File: rtl/axi4_to_pi1.sv
// AXI4 slave to pi1 master bridge: each burst is split into single-word pi1
// operations, one outstanding at a time, with reads and writes alternating.
module axi4_to_pi1
  import pi1_pkg::*;
  import axi4_pkg::*;
#(
  parameter int  ARCHBITSZ     = 32,
  parameter int  AXI4_ID_WIDTH = 4,
  localparam int CLOG2B        = $clog2(ARCHBITSZ/8),
  localparam int ADDRBITSZ     = ARCHBITSZ - CLOG2B
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [AXI4_ID_WIDTH-1:0] axi4_awid_i,
  input  logic [ARCHBITSZ-1:0]     axi4_awaddr_i,
  input  logic [7:0]               axi4_awlen_i,
  input  logic [2:0]               axi4_awsize_i,
  input  logic [1:0]               axi4_awburst_i,
  input  logic                     axi4_awvalid_i,
  output logic                     axi4_awready_o,
  input  logic [ARCHBITSZ-1:0]     axi4_wdata_i,
  input  logic [ARCHBITSZ/8-1:0]   axi4_wstrb_i,
  input  logic                     axi4_wlast_i,
  input  logic                     axi4_wvalid_i,
  output logic                     axi4_wready_o,
  output logic [AXI4_ID_WIDTH-1:0] axi4_bid_o,
  output logic [1:0]               axi4_bresp_o,
  output logic                     axi4_bvalid_o,
  input  logic                     axi4_bready_i,
  input  logic [AXI4_ID_WIDTH-1:0] axi4_arid_i,
  input  logic [ARCHBITSZ-1:0]     axi4_araddr_i,
  input  logic [7:0]               axi4_arlen_i,
  input  logic [2:0]               axi4_arsize_i,
  input  logic [1:0]               axi4_arburst_i,
  input  logic                     axi4_arvalid_i,
  output logic                     axi4_arready_o,
  output logic [AXI4_ID_WIDTH-1:0] axi4_rid_o,
  output logic [ARCHBITSZ-1:0]     axi4_rdata_o,
  output logic [1:0]               axi4_rresp_o,
  output logic                     axi4_rlast_o,
  output logic                     axi4_rvalid_o,
  input  logic                     axi4_rready_i,
  output logic [1:0]               pi1_op_o,
  output logic [ADDRBITSZ-1:0]     pi1_addr_o,
  output logic [ARCHBITSZ-1:0]     pi1_data_o,
  input  logic [ARCHBITSZ-1:0]     pi1_data_i,
  output logic [ARCHBITSZ/8-1:0]   pi1_sel_o,
  input  logic                     pi1_rdy_i
);

  typedef enum logic [2:0] {
    IDLE, WR_ISSUE, WR_WAIT, WR_RESP, RD_ISSUE, RD_WAIT, RD_DATA
  } state_e;

  state_e                   state_q, state_d;
  logic [AXI4_ID_WIDTH-1:0] id_q;
  logic [ARCHBITSZ-1:0]     addr_q, addr_nxt;
  logic [7:0]               cnt_q;
  logic [2:0]               size_q;
  logic [1:0]               burst_q;
  logic                     last_wr_q, berr_q, burst_err;
  logic [ARCHBITSZ-1:0]     rdata_q;
  logic [1:0]               rresp_q;
  logic                     rlast_q;
  logic                     aw_acc, ar_acc, wr_skip, beat_done;
  logic                     unused_wlast;

  assign unused_wlast = axi4_wlast_i;

  axi4_burst_addr #(.ARCHBITSZ(ARCHBITSZ)) u_burst_addr (
    .addr      (addr_q),
    .size      (size_q),
    .burst     (burst_q),
    .next_addr (addr_nxt),
    .err       (burst_err)
  );

  // last_wr breaks ties: whichever direction did not go last wins.
  assign aw_acc  = rst_n_i && (state_q == IDLE) && axi4_awvalid_i && !(axi4_arvalid_i && last_wr_q);
  assign ar_acc  = rst_n_i && (state_q == IDLE) && axi4_arvalid_i && !(axi4_awvalid_i && !last_wr_q);
  assign wr_skip = burst_err || (axi4_wstrb_i == '0);

  assign beat_done = ((state_q == WR_ISSUE) && wr_skip && axi4_wvalid_i)
                  || ((state_q == WR_WAIT) && pi1_rdy_i)
                  || ((state_q == RD_DATA) && axi4_rready_i);

  assign pi1_addr_o    = addr_q[ARCHBITSZ-1:CLOG2B];
  assign axi4_bid_o    = id_q;
  assign axi4_rid_o    = id_q;
  assign axi4_bresp_o  = berr_q ? RESP_SLVERR : RESP_OKAY;
  assign axi4_bvalid_o = rst_n_i && (state_q == WR_RESP);
  assign axi4_rvalid_o = rst_n_i && (state_q == RD_DATA);
  assign axi4_rlast_o  = axi4_rvalid_o && rlast_q;
  assign axi4_rdata_o  = rdata_q;
  assign axi4_rresp_o  = rresp_q;

  always_comb begin
    state_d        = state_q;
    axi4_awready_o = 1'b0;
    axi4_arready_o = 1'b0;
    axi4_wready_o  = 1'b0;
    pi1_op_o       = PINOOP;
    pi1_sel_o      = '0;
    pi1_data_o     = '0;
    case (state_q)
      IDLE: begin
        axi4_awready_o = aw_acc;
        axi4_arready_o = ar_acc;
        if (aw_acc)      state_d = WR_ISSUE;
        else if (ar_acc) state_d = RD_ISSUE;
      end
      WR_ISSUE: begin
        pi1_sel_o  = axi4_wstrb_i;
        pi1_data_o = axi4_wdata_i;
        if (wr_skip) begin
          // Nothing to put on pi1: swallow the beat in place.
          axi4_wready_o = 1'b1;
          if (axi4_wvalid_i && (cnt_q == '0)) state_d = WR_RESP;
        end else begin
          axi4_wready_o = pi1_rdy_i;
          pi1_op_o      = axi4_wvalid_i ? PIWROP : PINOOP;
          if (axi4_wvalid_i && pi1_rdy_i) state_d = WR_WAIT;
        end
      end
      WR_WAIT:  if (pi1_rdy_i) state_d = (cnt_q == '0) ? WR_RESP : WR_ISSUE;
      WR_RESP:  if (axi4_bready_i) state_d = IDLE;
      RD_ISSUE: begin
        if (burst_err) state_d = RD_DATA;
        else begin
          pi1_op_o  = PIRDOP;
          pi1_sel_o = '1;
          if (pi1_rdy_i) state_d = RD_WAIT;
        end
      end
      RD_WAIT:  if (pi1_rdy_i) state_d = RD_DATA;
      RD_DATA:  if (axi4_rready_i) state_d = rlast_q ? IDLE : RD_ISSUE;
      default:  state_d = IDLE;
    endcase
    if (!rst_n_i) begin
      axi4_wready_o = 1'b0;
      pi1_op_o      = PINOOP;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      last_wr_q <= 1'b1;
      id_q      <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      berr_q    <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rlast_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (aw_acc) begin
        id_q      <= axi4_awid_i;
        addr_q    <= axi4_awaddr_i;
        cnt_q     <= axi4_awlen_i;
        size_q    <= axi4_awsize_i;
        burst_q   <= axi4_awburst_i;
        last_wr_q <= 1'b1;
        berr_q    <= 1'b0;
      end else if (ar_acc) begin
        id_q      <= axi4_arid_i;
        addr_q    <= axi4_araddr_i;
        cnt_q     <= axi4_arlen_i;
        size_q    <= axi4_arsize_i;
        burst_q   <= axi4_arburst_i;
        last_wr_q <= 1'b0;
      end
      if (beat_done && (cnt_q != '0)) begin
        cnt_q  <= cnt_q - 8'd1;
        addr_q <= addr_nxt;
      end
      if ((state_q == WR_ISSUE) && axi4_wvalid_i && burst_err) berr_q <= 1'b1;
      if ((state_q == RD_ISSUE) && burst_err) begin
        rdata_q <= '0;
        rresp_q <= RESP_SLVERR;
        rlast_q <= (cnt_q == '0);
      end
      if ((state_q == RD_WAIT) && pi1_rdy_i) begin
        rdata_q <= pi1_data_i;
        rresp_q <= RESP_OKAY;
        rlast_q <= (cnt_q == '0);
      end
    end
  end

endmodule
